// File: rtl/program_loader.sv
// Streams 16-bit instruction words into byte-wide memory (big-endian) from a base address,
// holding the CPU in reset until the load completes, then publishing the entry PC.
module program_loader #(
    parameter int unsigned       ADDR_W     = 16,
    parameter logic [ADDR_W-1:0] ADDR_LIMIT = 16'h00FF
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Start,
    input  logic [ADDR_W-1:0] Base_Addr,
    input  logic              Abort,
    input  logic [15:0]       Word_In,
    input  logic              Word_Valid,
    input  logic              Word_Last,
    output logic              Word_Ready,
    output logic [ADDR_W-1:0] Mem_Address,
    output logic [7:0]        Mem_Data,
    output logic              Mem_CS,
    output logic              Mem_WR,
    output logic              CPU_Reset,
    output logic [ADDR_W-1:0] Entry_PC,
    output logic [7:0]        Word_Count,
    output logic              Busy,
    output logic              Done,
    output logic              Error
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_WORD,
        WR_HI,
        WR_LO,
        FINISH
    } state_t;

    state_t            state;
    // One extra bit so the pointer can run past the top of the address space without wrapping.
    logic [ADDR_W:0]   ptr;
    logic [ADDR_W-1:0] base;
    logic [7:0]        lo_byte;
    logic              last_q;

    logic [ADDR_W:0]   ptr_inc;
    logic              overflow;
    logic              handshake;

    assign ptr_inc   = ptr + (ADDR_W+1)'(1);
    assign overflow  = ptr_inc > {1'b0, ADDR_LIMIT};
    assign handshake = Word_Valid && Word_Ready;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state       <= IDLE;
            ptr         <= '0;
            base        <= '0;
            lo_byte     <= '0;
            last_q      <= 1'b0;
            Word_Ready  <= 1'b0;
            Mem_Address <= '0;
            Mem_Data    <= '0;
            Mem_CS      <= 1'b1;
            Mem_WR      <= 1'b0;
            CPU_Reset   <= 1'b1;
            Entry_PC    <= '0;
            Word_Count  <= '0;
            Busy        <= 1'b0;
            Done        <= 1'b0;
            Error       <= 1'b0;
        end else begin
            Done <= 1'b0;
            if (Abort && state != IDLE) begin
                state      <= IDLE;
                Word_Ready <= 1'b0;
                Mem_CS     <= 1'b1;
                Mem_WR     <= 1'b0;
                Busy       <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (Start) begin
                            base       <= Base_Addr;
                            ptr        <= {1'b0, Base_Addr};
                            Word_Count <= '0;
                            Error      <= 1'b0;
                            CPU_Reset  <= 1'b1;
                            Word_Ready <= 1'b1;
                            Busy       <= 1'b1;
                            state      <= WAIT_WORD;
                        end
                    end
                    WAIT_WORD: begin
                        if (handshake) begin
                            Word_Ready <= 1'b0;
                            if (overflow) begin
                                Error <= 1'b1;
                                Busy  <= 1'b0;
                                state <= IDLE;
                            end else begin
                                lo_byte     <= Word_In[7:0];
                                last_q      <= Word_Last;
                                Mem_CS      <= 1'b0;
                                Mem_WR      <= 1'b1;
                                Mem_Address <= ptr[ADDR_W-1:0];
                                Mem_Data    <= Word_In[15:8];
                                state       <= WR_HI;
                            end
                        end
                    end
                    WR_HI: begin
                        Mem_Address <= ptr_inc[ADDR_W-1:0];
                        Mem_Data    <= lo_byte;
                        state       <= WR_LO;
                    end
                    WR_LO: begin
                        Mem_CS <= 1'b1;
                        Mem_WR <= 1'b0;
                        ptr    <= ptr + (ADDR_W+1)'(2);
                        if (Word_Count != 8'hFF) begin
                            Word_Count <= Word_Count + 8'd1;
                        end
                        if (last_q) begin
                            Entry_PC  <= base;
                            CPU_Reset <= 1'b0;
                            Done      <= 1'b1;
                            state     <= FINISH;
                        end else begin
                            Word_Ready <= 1'b1;
                            state      <= WAIT_WORD;
                        end
                    end
                    FINISH: begin
                        Busy  <= 1'b0;
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: a write-queue/memory model predicts every byte written,
// and a per-cycle compare process checks the memory port against it.
module tb_program_loader;

    localparam int unsigned LIMIT = 'hFF;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        Start = 1'b0;
    logic [15:0] Base_Addr = '0;
    logic        Abort = 1'b0;
    logic [15:0] Word_In = '0;
    logic        Word_Valid = 1'b0;
    logic        Word_Last = 1'b0;
    logic        Word_Ready;
    logic [15:0] Mem_Address;
    logic [7:0]  Mem_Data;
    logic        Mem_CS;
    logic        Mem_WR;
    logic        CPU_Reset;
    logic [15:0] Entry_PC;
    logic [7:0]  Word_Count;
    logic        Busy;
    logic        Done;
    logic        Error;

    program_loader #(.ADDR_W(16), .ADDR_LIMIT(16'h00FF)) dut (
        .Clock(Clock), .Reset(Reset), .Start(Start), .Base_Addr(Base_Addr), .Abort(Abort),
        .Word_In(Word_In), .Word_Valid(Word_Valid), .Word_Last(Word_Last), .Word_Ready(Word_Ready),
        .Mem_Address(Mem_Address), .Mem_Data(Mem_Data), .Mem_CS(Mem_CS), .Mem_WR(Mem_WR),
        .CPU_Reset(CPU_Reset), .Entry_PC(Entry_PC), .Word_Count(Word_Count), .Busy(Busy),
        .Done(Done), .Error(Error)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
    } wr_t;

    wr_t         exp_q[$];
    logic [7:0]  exp_mem [0:255];
    logic [7:0]  dut_mem [0:255];
    int unsigned model_ptr = 0;
    int unsigned model_base = 0;
    int          checks = 0;
    int          passes = 0;
    int          done_cnt = 0;
    int          cs_low_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Memory-port observer: every chip-select cycle must be the next write the model predicted.
    always @(negedge Clock) begin
        if (Mem_CS === 1'b0) begin
            wr_t e;
            cs_low_cnt++;
            dut_mem[Mem_Address[7:0]] = Mem_Data;
            if (exp_q.size() == 0) begin
                check("spurious_write", 32'(Mem_CS), 32'd1);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", 32'(Mem_Address), 32'(e.addr));
                check("wr_data", 32'(Mem_Data), 32'(e.data));
                check("wr_en", 32'(Mem_WR), 32'd1);
            end
        end else begin
            check("idle_wr", 32'(Mem_WR), 32'd0);
        end
        if (Done === 1'b1) done_cnt++;
    end

    task automatic clear_mems();
        for (int i = 0; i < 256; i++) begin
            dut_mem[i] = 8'hEE;
            exp_mem[i] = 8'hEE;
        end
    endtask

    task automatic check_mem(input int lo, input int hi);
        for (int i = lo; i <= hi; i++)
            check($sformatf("mem_%02h", i), 32'(dut_mem[i]), 32'(exp_mem[i]));
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_cs"}, 32'(Mem_CS), 32'd1);
        check({tag, "_wr"}, 32'(Mem_WR), 32'd0);
        check({tag, "_addr"}, 32'(Mem_Address), 32'd0);
        check({tag, "_data"}, 32'(Mem_Data), 32'd0);
        check({tag, "_cpu_reset"}, 32'(CPU_Reset), 32'd1);
        check({tag, "_entry_pc"}, 32'(Entry_PC), 32'd0);
        check({tag, "_count"}, 32'(Word_Count), 32'd0);
        check({tag, "_ready"}, 32'(Word_Ready), 32'd0);
        check({tag, "_busy"}, 32'(Busy), 32'd0);
        check({tag, "_done"}, 32'(Done), 32'd0);
        check({tag, "_error"}, 32'(Error), 32'd0);
    endtask

    task automatic start_load(input logic [15:0] base);
        Base_Addr = base;
        Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        model_ptr = 32'(base);
        model_base = 32'(base);
        check("start_busy", 32'(Busy), 32'd1);
        check("start_ready", 32'(Word_Ready), 32'd1);
        check("start_error", 32'(Error), 32'd0);
        check("start_count", 32'(Word_Count), 32'd0);
        check("start_cpu_reset", 32'(CPU_Reset), 32'd1);
    endtask

    // Offers one word after 'gap' idle cycles and checks the accept/hi/lo/next timeline.
    task automatic send_word(input logic [15:0] w, input logic last, input int gap);
        int unsigned p;
        logic        ovf;
        int          t;
        for (int i = 0; i < gap; i++) begin
            check("gap_cs", 32'(Mem_CS), 32'd1);
            @(negedge Clock);
        end
        p   = model_ptr;
        ovf = (p + 1 > LIMIT);
        if (!ovf) begin
            exp_q.push_back('{16'(p), w[15:8]});
            exp_q.push_back('{16'(p + 1), w[7:0]});
            exp_mem[p]     = w[15:8];
            exp_mem[p + 1] = w[7:0];
            model_ptr      = p + 2;
        end
        Word_In = w;
        Word_Last = last;
        Word_Valid = 1'b1;
        t = 0;
        while (Word_Ready !== 1'b1 && t < 20) begin
            @(negedge Clock);
            t++;
        end
        if (t >= 20) begin
            check("ready_timeout", 32'(Word_Ready), 32'd1);
            Word_Valid = 1'b0;
            return;
        end
        @(negedge Clock);
        Word_Valid = 1'b0;
        Word_Last = 1'b0;
        if (ovf) begin
            check("ovf_error", 32'(Error), 32'd1);
            check("ovf_busy", 32'(Busy), 32'd0);
            check("ovf_cs", 32'(Mem_CS), 32'd1);
            check("ovf_cpu_reset", 32'(CPU_Reset), 32'd1);
            return;
        end
        check("hi_cs", 32'(Mem_CS), 32'd0);
        check("hi_addr", 32'(Mem_Address), p);
        check("hi_data", 32'(Mem_Data), 32'(w[15:8]));
        check("hi_ready", 32'(Word_Ready), 32'd0);
        @(negedge Clock);
        check("lo_cs", 32'(Mem_CS), 32'd0);
        check("lo_addr", 32'(Mem_Address), p + 1);
        check("lo_data", 32'(Mem_Data), 32'(w[7:0]));
        check("lo_cpu_reset", 32'(CPU_Reset), 32'd1);
        @(negedge Clock);
        check("after_cs", 32'(Mem_CS), 32'd1);
        if (last) begin
            check("fin_done", 32'(Done), 32'd1);
            check("fin_cpu_reset", 32'(CPU_Reset), 32'd0);
            check("fin_entry_pc", 32'(Entry_PC), model_base);
        end else begin
            check("next_ready", 32'(Word_Ready), 32'd1);
            check("next_done", 32'(Done), 32'd0);
        end
    endtask

    initial begin
        int d0;
        int c0;

        clear_mems();
        repeat (2) @(negedge Clock);
        check_reset_vals("reset");
        Reset = 1'b0;
        @(negedge Clock);

        // Three-word load at 0x26 without gaps.
        d0 = done_cnt;
        c0 = cs_low_cnt;
        start_load(16'h0026);
        send_word(16'h6501, 1'b0, 0);
        send_word(16'h6404, 1'b0, 0);
        send_word(16'h6240, 1'b1, 0);
        check("s1_count", 32'(Word_Count), 32'd3);
        check("s1_entry_pc", 32'(Entry_PC), 32'h26);
        @(negedge Clock);
        check("s1_done_once", 32'(done_cnt - d0), 32'd1);
        check("s1_cs_cycles", 32'(cs_low_cnt - c0), 32'd6);
        check("s1_busy_end", 32'(Busy), 32'd0);
        check("s1_cpu_reset_end", 32'(CPU_Reset), 32'd0);
        check_mem('h26, 'h2B);
        check("s1_lit26", 32'(dut_mem[8'h26]), 32'h65);
        check("s1_lit27", 32'(dut_mem[8'h27]), 32'h01);
        check("s1_lit28", 32'(dut_mem[8'h28]), 32'h64);
        check("s1_lit29", 32'(dut_mem[8'h29]), 32'h04);
        check("s1_lit2a", 32'(dut_mem[8'h2A]), 32'h62);
        check("s1_lit2b", 32'(dut_mem[8'h2B]), 32'h40);

        // Same load with 5-cycle valid gaps.
        clear_mems();
        d0 = done_cnt;
        c0 = cs_low_cnt;
        start_load(16'h0026);
        send_word(16'h6501, 1'b0, 5);
        send_word(16'h6404, 1'b0, 5);
        send_word(16'h6240, 1'b1, 5);
        @(negedge Clock);
        check("s2_done_once", 32'(done_cnt - d0), 32'd1);
        check("s2_cs_cycles", 32'(cs_low_cnt - c0), 32'd6);
        check("s2_count", 32'(Word_Count), 32'd3);
        check_mem('h26, 'h2B);

        // Overflow near the top of the address range.
        clear_mems();
        d0 = done_cnt;
        start_load(16'h00FC);
        send_word(16'h1111, 1'b0, 0);
        send_word(16'h2222, 1'b0, 0);
        send_word(16'h3333, 1'b0, 0);
        @(negedge Clock);
        check("s3_error", 32'(Error), 32'd1);
        check("s3_no_done", 32'(done_cnt - d0), 32'd0);
        check("s3_cpu_reset", 32'(CPU_Reset), 32'd1);
        check("s3_busy", 32'(Busy), 32'd0);
        check("s3_count", 32'(Word_Count), 32'd2);
        check_mem('hFC, 'hFF);
        check("s3_litfc", 32'(dut_mem[8'hFC]), 32'h11);
        check("s3_litff", 32'(dut_mem[8'hFF]), 32'h22);

        // Start while busy is ignored; Abort wins over a simultaneous handshake.
        clear_mems();
        d0 = done_cnt;
        start_load(16'h0050);
        send_word(16'h1234, 1'b0, 0);
        Base_Addr = 16'h0090;
        Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        check("s6_busy_after_start", 32'(Busy), 32'd1);
        check("s6_ready_after_start", 32'(Word_Ready), 32'd1);
        send_word(16'h5678, 1'b0, 0);
        Word_In = 16'hDEAD;
        Word_Valid = 1'b1;
        Abort = 1'b1;
        @(negedge Clock);
        Abort = 1'b0;
        Word_Valid = 1'b0;
        check("s6_abort_busy", 32'(Busy), 32'd0);
        check("s6_abort_ready", 32'(Word_Ready), 32'd0);
        check("s6_abort_cpu_reset", 32'(CPU_Reset), 32'd1);
        check("s6_abort_cs", 32'(Mem_CS), 32'd1);
        check("s6_abort_count", 32'(Word_Count), 32'd2);
        repeat (3) @(negedge Clock);
        check("s6_no_done", 32'(done_cnt - d0), 32'd0);
        check_mem('h50, 'h53);
        check("s6_lit52", 32'(dut_mem[8'h52]), 32'h56);
        check("s6_lit90", 32'(dut_mem[8'h90]), 32'hEE);

        // Fresh Start after the abort: single Last word.
        clear_mems();
        d0 = done_cnt;
        start_load(16'h0060);
        send_word(16'h1C32, 1'b1, 0);
        check("s4_count", 32'(Word_Count), 32'd1);
        @(negedge Clock);
        check("s4_done_once", 32'(done_cnt - d0), 32'd1);
        check("s4_entry_pc", 32'(Entry_PC), 32'h60);
        check("s4_lit60", 32'(dut_mem[8'h60]), 32'h1C);
        check("s4_lit61", 32'(dut_mem[8'h61]), 32'h32);

        // Reset during the high-byte write of the second word.
        clear_mems();
        start_load(16'h0080);
        send_word(16'hA1B2, 1'b0, 0);
        exp_q.push_back('{16'h0082, 8'hC3});
        exp_q.push_back('{16'h0083, 8'hD4});
        Word_In = 16'hC3D4;
        Word_Valid = 1'b1;
        @(negedge Clock);
        Word_Valid = 1'b0;
        check("s5_hi_addr", 32'(Mem_Address), 32'h82);
        check("s5_hi_data", 32'(Mem_Data), 32'hC3);
        Reset = 1'b1;
        @(negedge Clock);
        check_reset_vals("s5");
        Reset = 1'b0;
        exp_q.delete();
        repeat (3) @(negedge Clock);
        check("s5_lit80", 32'(dut_mem[8'h80]), 32'hA1);
        check("s5_lit81", 32'(dut_mem[8'h81]), 32'hB2);
        check("s5_lit82", 32'(dut_mem[8'h82]), 32'hC3);
        check("s5_lit83", 32'(dut_mem[8'h83]), 32'hEE);
        check("s5_idle_busy", 32'(Busy), 32'd0);

        check("pending_writes", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
